// File: rtl/mem_wb_stage.sv
// Memory / write-back pipeline stage with a 256-byte big-endian data memory.
// Define MISALIGN_TRAP_EN to trap misaligned memory ops instead of wrapping byte accesses.
module mem_wb_stage (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] ALUOut,
    input  logic [31:0] StoreData,
    input  logic [4:0]  WriteRegIn,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    output logic        WB_VALID,
    output logic        WB_EN,
    output logic [4:0]  WB_REG,
    output logic [31:0] WB_DATA,
    output logic        MISALIGN
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM,
        S_WB
    } state_t;

    state_t state_q, state_d;

    logic [31:0] lat_alu, lat_sd;
    logic [4:0]  lat_reg;
    logic        lat_rd, lat_wr, lat_m2r, lat_rw;

    logic        accept;
    logic        trap;
    logic        mem_rd, mem_we;
    logic [7:0]  a0, a1, a2, a3;
    logic [31:0] rd_word, load_word;

    logic        wb_ld;
    logic [4:0]  wb_reg_d, wb_reg_q;
    logic [31:0] wb_data_d, wb_data_q;

    // Contents survive reset; only the power-up value is defined.
    logic [7:0]  mem [256] = '{default: 8'h00};

    assign accept = IN_VALID & IN_READY;

`ifdef MISALIGN_TRAP_EN
    assign trap     = (lat_rd | lat_wr) & (lat_alu[1:0] != 2'b00);
    assign MISALIGN = (state_q == S_WB) & trap;
`else
    assign trap     = 1'b0;
    assign MISALIGN = 1'b0;
`endif

    assign a0 = lat_alu[7:0];
    assign a1 = a0 + 8'd1;
    assign a2 = a0 + 8'd2;
    assign a3 = a0 + 8'd3;

    // Store wins over load when both are requested.
    assign mem_we    = (state_q == S_MEM) & lat_wr & ~trap;
    assign mem_rd    = (state_q == S_MEM) & lat_rd & ~lat_wr & ~trap;
    assign rd_word   = {mem[a0], mem[a1], mem[a2], mem[a3]};
    assign load_word = mem_rd ? rd_word : '0;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        IN_READY  = 1'b0;
        wb_ld     = 1'b0;
        wb_reg_d  = wb_reg_q;
        wb_data_d = wb_data_q;
        case (state_q)
            S_IDLE: begin
                IN_READY = RESET_N;
                if (accept) begin
                    if (MemRead | MemWrite) begin
                        state_d = S_MEM;
                    end else begin
                        state_d   = S_WB;
                        wb_ld     = 1'b1;
                        wb_reg_d  = WriteRegIn;
                        wb_data_d = MemtoReg ? '0 : ALUOut;
                    end
                end
            end
            S_MEM: begin
                state_d   = S_WB;
                wb_ld     = 1'b1;
                wb_reg_d  = lat_reg;
                wb_data_d = lat_m2r ? load_word : lat_alu;
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lat_alu <= '0;
            lat_sd  <= '0;
            lat_reg <= '0;
            lat_rd  <= 1'b0;
            lat_wr  <= 1'b0;
            lat_m2r <= 1'b0;
            lat_rw  <= 1'b0;
        end else if (accept) begin
            lat_alu <= ALUOut;
            lat_sd  <= StoreData;
            lat_reg <= WriteRegIn;
            lat_rd  <= MemRead;
            lat_wr  <= MemWrite;
            lat_m2r <= MemtoReg;
            lat_rw  <= RegWrite;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wb_reg_q  <= '0;
            wb_data_q <= '0;
        end else if (wb_ld) begin
            wb_reg_q  <= wb_reg_d;
            wb_data_q <= wb_data_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[a0] <= lat_sd[31:24];
            mem[a1] <= lat_sd[23:16];
            mem[a2] <= lat_sd[15:8];
            mem[a3] <= lat_sd[7:0];
        end
    end

    assign WB_VALID = (state_q == S_WB);
    assign WB_EN    = (state_q == S_WB) & lat_rw & ~trap;
    assign WB_REG   = wb_reg_q;
    assign WB_DATA  = wb_data_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a byte-level memory model predicts each write-back.
module tb_mem_wb_stage;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] ALUOut, StoreData;
    logic [4:0]  WriteRegIn;
    logic        MemRead, MemWrite, MemtoReg, RegWrite;
    logic        WB_VALID, WB_EN, MISALIGN;
    logic [4:0]  WB_REG;
    logic [31:0] WB_DATA;

    mem_wb_stage dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .ALUOut    (ALUOut),
        .StoreData (StoreData),
        .WriteRegIn(WriteRegIn),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .WB_VALID  (WB_VALID),
        .WB_EN     (WB_EN),
        .WB_REG    (WB_REG),
        .WB_DATA   (WB_DATA),
        .MISALIGN  (MISALIGN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        en;
        logic [4:0]  rg;
        logic [31:0] data;
        logic        mis;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [7:0]  model [256];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc_n = 0;
    logic [4:0]  last_reg = '0;
    logic [31:0] last_data = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic rd, input logic wr, input logic m2r, input logic rw,
                        input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] wreg,
                        input bit drop);
        exp_t        e;
        logic [7:0]  a;
        logic [31:0] ld;
        logic        mis;
        int          n;
`ifdef MISALIGN_TRAP_EN
        mis = (rd | wr) && (alu[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        a  = alu[7:0];
        ld = '0;
        if ((rd | wr) && !mis) begin
            if (wr) begin
                if (!drop) begin
                    model[a]              = sd[31:24];
                    model[8'(a + 8'd1)]   = sd[23:16];
                    model[8'(a + 8'd2)]   = sd[15:8];
                    model[8'(a + 8'd3)]   = sd[7:0];
                end
            end else begin
                ld = {model[a], model[8'(a + 8'd1)], model[8'(a + 8'd2)], model[8'(a + 8'd3)]};
            end
        end
        e.en   = rw & ~mis;
        e.rg   = wreg;
        e.data = m2r ? ld : alu;
        e.mis  = mis;
        e.lat  = (rd | wr) ? 2 : 1;

        @(negedge CLK);
        IN_VALID   = 1'b1;
        ALUOut     = alu;
        StoreData  = sd;
        WriteRegIn = wreg;
        MemRead    = rd;
        MemWrite   = wr;
        MemtoReg   = m2r;
        RegWrite   = rw;
        n = 0;
        while (!IN_READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!IN_READY) begin
            check("ready_timeout", 64'd0, 64'd1);
            return;
        end
        @(posedge CLK);
        e.acc = cyc_n;
        if (!drop) sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    // Output monitor: pops one expectation per write-back strobe, otherwise checks idle/hold behaviour.
    always @(negedge CLK) begin
        if (!RESET_N) begin
            check("rst_wb_valid", WB_VALID, 0);
            check("rst_wb_reg", WB_REG, 0);
            check("rst_wb_data", WB_DATA, 0);
            last_reg  = '0;
            last_data = '0;
        end else if (WB_VALID) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("wb_en", WB_EN, mon_e.en);
                check("wb_reg", WB_REG, mon_e.rg);
                check("wb_data", WB_DATA, mon_e.data);
                check("wb_misalign", MISALIGN, mon_e.mis);
                check("wb_latency", 64'(cyc_n - mon_e.acc + 1), 64'(mon_e.lat));
                last_reg  = mon_e.rg;
                last_data = mon_e.data;
            end
        end else begin
            check("idle_wb_en", WB_EN, 0);
            check("idle_misalign", MISALIGN, 0);
            check("hold_wb_reg", WB_REG, last_reg);
            check("hold_wb_data", WB_DATA, last_data);
        end
        cyc_n++;
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        RESET_N    = 1'b0;
        IN_VALID   = 1'b0;
        ALUOut     = '0;
        StoreData  = '0;
        WriteRegIn = '0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;

        repeat (2) @(negedge CLK);
        check("rst_in_ready", IN_READY, 0);
        check("rst_misalign", MISALIGN, 0);
        RESET_N = 1'b1;
        @(negedge CLK);
        check("ready_after_rst", IN_READY, 1);

        // ALU op, store then load, wrapped address, register 0, store/load precedence
        send(0, 0, 0, 1, 32'h7, 32'h0, 5'd2, 0);
        send(0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 5'd3, 0);
        send(1, 0, 1, 1, 32'h10, 32'h0, 5'd5, 0);
        send(0, 1, 0, 0, 32'h1FC, 32'h11223344, 5'd0, 0);
        send(1, 0, 1, 1, 32'hFC, 32'h0, 5'd6, 0);
        send(0, 1, 0, 0, 32'hFE, 32'hA1B2C3D4, 5'd0, 0);
        send(1, 0, 1, 1, 32'hFE, 32'h0, 5'd8, 0);
        send(0, 0, 0, 1, 32'h12345678, 32'h0, 5'd0, 0);
        send(1, 1, 1, 1, 32'h30, 32'h55667788, 5'd9, 0);
        send(1, 0, 1, 1, 32'h30, 32'h0, 5'd10, 0);
        idle();

        // Back-to-back with IN_VALID held high
        send(0, 0, 0, 1, 32'hAAA, 32'h0, 5'd11, 0);
        #1 check("bp_ready_low", IN_READY, 0);
        send(0, 0, 0, 1, 32'hBBB, 32'h0, 5'd12, 0);
        idle();

        send(1, 0, 1, 1, 32'h13, 32'h0, 5'd7, 0);

        for (int i = 0; i < 10; i++) begin
            logic [31:0] addr;
            addr = 32'h40 + 32'($urandom_range(0, 15)) * 4;
            case ($urandom_range(0, 2))
                0: send(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        $urandom, $urandom, 5'($urandom_range(0, 31)), 0);
                1: send(0, 1, 0, 0, addr, $urandom, 5'($urandom_range(0, 31)), 0);
                default: send(1, 0, 1, 1, addr, 32'h0, 5'($urandom_range(0, 31)), 0);
            endcase
        end
        idle();

        // Reset while the store sits in MEM: store aborted, transaction dropped
        send(0, 1, 0, 0, 32'h20, 32'hCAFEF00D, 5'd4, 1);
        #2 RESET_N = 1'b0;
        IN_VALID = 1'b0;
        #1;
        check("midrst_wb_valid", WB_VALID, 0);
        check("midrst_in_ready", IN_READY, 0);
        check("midrst_wb_reg", WB_REG, 0);
        check("midrst_wb_data", WB_DATA, 0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        send(1, 0, 1, 1, 32'h20, 32'h0, 5'd13, 0);
        idle();

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("sb_drain", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
